// File: rtl/float_pkg.sv
// Shared binary32 format constants and the operand class enum used by the
// reciprocal fix-up wrapper and its delay lines.
package float_pkg;

    localparam int FLOAT_MANT_SIZE = 23;
    localparam int FLOAT_EXP_SIZE  = 8;
    localparam int FLOAT_SIZE      = 1 + FLOAT_EXP_SIZE + FLOAT_MANT_SIZE;
    localparam int EXPONENT_BIAS   = 127;
    localparam int EXPONENT_INF    = 255;
    localparam logic [FLOAT_SIZE-1:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        NORM = 3'd0,
        ZERO = 3'd1,
        INF  = 3'd2,
        NAN  = 3'd3,
        UFL  = 3'd4
    } float_class_e;

endpackage

// File: rtl/float_valid_delay.sv
// Enabled shift-register delay line with synchronous clear; used for the
// valid, sign/class and flag pipelines that track the external core.
module float_valid_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = d_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/float_recip_fixup.sv
// Wraps an external fixed-latency reciprocal core: classifies operands on entry
// and substitutes IEEE special results at the output. Optional m_flags port
// {DZ, INV, UF} is enabled by defining FLOAT_RECIP_FIXUP_FLAGS_EN.
module float_recip_fixup
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int CORE_LATENCY  = 11,
    localparam int FW = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [FW-1:0] s_data,
    output logic          core_ce,
    output logic [FW-1:0] core_in,
    input  logic [FW-1:0] core_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [FW-1:0] m_data
`ifdef FLOAT_RECIP_FIXUP_FLAGS_EN
    ,
    output logic [2:0]    m_flags
`endif
);

    localparam logic [EXPONENT_SIZE-1:0] EXP_ONES   = '1;
    localparam logic [EXPONENT_SIZE-1:0] EXP_UFL_HI = {{(EXPONENT_SIZE-1){1'b1}}, 1'b0};
    localparam logic [EXPONENT_SIZE-1:0] EXP_UFL_LO = {{(EXPONENT_SIZE-2){1'b1}}, 2'b01};
    localparam logic [FW-1:0] NAN_CANON =
        {1'b0, EXP_ONES, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};

    logic                     advance;
    logic                     accept;
    logic                     in_sign;
    logic [EXPONENT_SIZE-1:0] in_exp;
    logic [MANTISSA_SIZE-1:0] in_mant;
    float_class_e             in_cls;
    logic                     head_valid;
    logic [3:0]               head_tag;
    logic                     head_sign;
    float_class_e             head_cls;
    logic [FW-1:0]            fixed_data;

    logic          m_valid_q, m_valid_d;
    logic [FW-1:0] m_data_q,  m_data_d;

    assign advance = !m_valid_q || m_ready;
    assign accept  = s_valid && advance;
    assign s_ready = advance;
    assign core_ce = advance;
    assign core_in = s_data;

    assign in_sign = s_data[FW-1];
    assign in_exp  = s_data[FW-2 -: EXPONENT_SIZE];
    assign in_mant = s_data[MANTISSA_SIZE-1:0];

    // Denormal inputs count as zero; the two largest exponents give results
    // below the smallest normal and are flushed.
    always_comb begin
        in_cls = NORM;
        if (in_exp == '0) begin
            in_cls = ZERO;
        end else if (in_exp == EXP_ONES) begin
            in_cls = (in_mant == '0) ? INF : NAN;
        end else if (in_exp == EXP_UFL_HI || (in_exp == EXP_UFL_LO && in_mant != '0)) begin
            in_cls = UFL;
        end
    end

    float_valid_delay #(.WIDTH(1), .DEPTH(CORE_LATENCY)) u_valid_dly (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .d_in  (accept),
        .d_out (head_valid)
    );

    float_valid_delay #(.WIDTH(4), .DEPTH(CORE_LATENCY)) u_class_dly (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .d_in  ({in_sign, in_cls}),
        .d_out (head_tag)
    );

    assign head_sign = head_tag[3];
    assign head_cls  = float_class_e'(head_tag[2:0]);

`ifdef FLOAT_RECIP_FIXUP_FLAGS_EN
    logic [2:0] in_flags;
    logic [2:0] head_flags;
    logic [2:0] m_flags_q, m_flags_d;

    assign in_flags = {in_cls == ZERO, in_cls == NAN, in_cls == UFL};

    float_valid_delay #(.WIDTH(3), .DEPTH(CORE_LATENCY)) u_flag_dly (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .d_in  (in_flags),
        .d_out (head_flags)
    );
`endif

    always_comb begin
        case (head_cls)
            ZERO:    fixed_data = {head_sign, EXP_ONES, {MANTISSA_SIZE{1'b0}}};
            INF:     fixed_data = {head_sign, {(FW-1){1'b0}}};
            NAN:     fixed_data = NAN_CANON;
            UFL:     fixed_data = {head_sign, {(FW-1){1'b0}}};
            default: fixed_data = core_out;
        endcase
    end

    // Output register reloads on the same edge it is consumed, so a steady
    // m_ready gives one result per cycle.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
`ifdef FLOAT_RECIP_FIXUP_FLAGS_EN
        m_flags_d = m_flags_q;
`endif
        if (advance) begin
            m_valid_d = head_valid;
            if (head_valid) begin
                m_data_d  = fixed_data;
`ifdef FLOAT_RECIP_FIXUP_FLAGS_EN
                m_flags_d = head_flags;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
`ifdef FLOAT_RECIP_FIXUP_FLAGS_EN
            m_flags_q <= '0;
`endif
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
`ifdef FLOAT_RECIP_FIXUP_FLAGS_EN
            m_flags_q <= m_flags_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
`ifdef FLOAT_RECIP_FIXUP_FLAGS_EN
    assign m_flags = m_flags_q;
`endif

endmodule

// File: doc/float_recip_fixup.md
FLOAT_RECIP_FIXUP -- requirements
Module: float_recip_fixup

Interface
REQ-001 SHALL have parameter MANTISSA_SIZE, default 23, mantissa width.
REQ-002 SHALL have parameter EXPONENT_SIZE, default 8, exponent width.
REQ-003 SHALL have parameter CORE_LATENCY, default 11, the reciprocal core's clock-enabled latency.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports s_valid in 1, s_ready out 1, s_data in FLOAT_SIZE  upstream operand stream.
REQ-007 SHALL have ports core_ce out 1, core_in out FLOAT_SIZE, core_out in FLOAT_SIZE  drive/consume the external reciprocal core.
REQ-008 SHALL have ports m_valid out 1, m_ready in 1, m_data out FLOAT_SIZE  result stream.
REQ-009 SHALL have port m_flags out 3 {DZ, INV, UF}, present only per REQ-024.

Function
REQ-010 SHALL compute advance = !m_valid || m_ready; core_ce = advance; s_ready = advance.
REQ-011 SHALL pass s_data to core_in combinationally; a transfer occurs when s_valid && s_ready.
REQ-012 SHALL keep a CORE_LATENCY-deep valid shift register plus sign/class delay line, shifting only when advance.
REQ-013 SHALL load the output register from core_out plus the delayed class when advance and the last valid stage is set; latency is CORE_LATENCY+1 = 12 cycles with no backpressure.
REQ-014 SHALL clear m_valid when advance and the last stage is empty; m_data holds its value while m_valid && !m_ready.
REQ-015 SHALL classify at input: ZERO (exp==0, denormals included), INF (exp all ones, mant==0), NAN (exp all ones, mant!=0), UFL (exp==2^E-2, or exp==2^E-3 with mant!=0), else NORM.
REQ-016 SHALL output: NORM -> core_out unchanged; ZERO -> ±inf, sign kept, DZ=1; INF -> ±0; NAN -> canonical quiet NaN, sign 0, exp all ones, mant MSB only, INV=1; UFL -> ±0, UF=1.
REQ-017 SHALL never emit a core_out value for a non-NORM class; core results for those slots are discarded.
REQ-018 SHALL preserve order; no result is lost or duplicated under any m_ready pattern.
REQ-019 SHALL sustain one result per cycle with m_ready held high.
REQ-020 SHALL, on simultaneous output handshake and head-valid, replace m_data in the same edge without a bubble.

Reset
REQ-021 SHALL clear all valid bits, m_valid=0, m_data=0, m_flags=0 on reset.
REQ-022 SHALL drop in-flight operands on reset mid-operation; stale core_out is ignored because the valid bits are cleared; first post-reset result appears 12 cycles after its acceptance.
REQ-023 SHALL drive s_ready=1 in the cycle after reset deasserts.

Configuration
REQ-024 SHALL, with FLOAT_RECIP_FIXUP_FLAGS_EN defined, instantiate the m_flags port and a 3-bit flag delay line; without it, omit the port and the flag storage, leaving m_data behaviour identical.

Structure
REQ-025 SHALL take FLOAT_SIZE, EXPONENT_BIAS, EXPONENT_INF, the canonical-NaN constant and the class enum (NORM, ZERO, INF, NAN, UFL) from shared package float_pkg.
REQ-026 SHALL implement the delay lines with one sub-module, float_valid_delay: parameterised width/depth, with enable and reset.
REQ-027 SHALL NOT instantiate the reciprocal core; the integrator connects it through the core_* ports.

Verification
REQ-028 SHALL check: 0x40000000 accepted, m_ready=1 -> m_data=0x3F000000, m_valid exactly 12 cycles later; 0x3F800000 -> 0x3F800000.
REQ-029 SHALL check: 0x00000000 -> 0x7F800000, DZ=1; 0x80000001 -> 0xFF800000, DZ=1; 0xFF800000 -> 0x80000000.
REQ-030 SHALL check: 0x7FC00001 -> 0x7FC00000, INV=1; 0x7F000000 -> 0x00000000, UF=1; 0x7E800000 -> 0x00800000, NORM.
REQ-031 SHALL check: 20 back-to-back operands with m_ready=1 -> 20 consecutive results in order, no bubbles.
REQ-032 SHALL check: 3 in flight with m_ready low for 15 cycles -> s_ready low while stalled, m_data stable, all 3 delivered in order after release.
REQ-033 SHALL check: reset asserted with 5 in flight -> m_valid=0 next cycle, no stale output afterwards, new operand result 12 cycles after acceptance.
